// File: rtl/uart_rx_bitstream.sv
// UART receive front end: synchronises rx, checks start/stop framing and emits each
// data bit as a one-cycle strobe (LSB first) plus frame status pulses.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for a low rx_s (start-bit edge)
// START     | counting to start-bit centre; high there means a glitch
// DATA      | sampling DATA_BITS data bits at their centres
// STOP      | sampling the stop bit at its centre
// WAIT_HIGH | stop bit was low (framing error/break); wait for line high
module uart_rx_bitstream #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic bit_out,
    output logic bit_valid,
    output logic frame_done,
    output logic frame_err,
    output logic busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          sync1, rx_s;
    logic          valid_nxt, done_nxt, err_nxt;

    // Synchroniser resets to the idle-line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            bit_valid  <= valid_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            if (valid_nxt) begin
                bit_out <= rx_s;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + IW'(1);
                    if (idx == IDX_LAST) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_bitstream.sv
// Directed bench for uart_rx_bitstream: table of frames with hand-computed bit sequences,
// plus glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx_bitstream;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic bit_out, bit_valid, frame_done, frame_err, busy;

    uart_rx_bitstream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #20 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Monitor: record strobes and pulses on the falling edge, away from the active edge.
    int   cycle = 0;
    logic bit_q[$];
    int   time_q[$];
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   overlap_cnt = 0;
    int   busy_cycles = 0;

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (bit_valid) begin
            bit_q.push_back(bit_out);
            time_q.push_back(cycle);
        end
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if ((bit_valid && (frame_done || frame_err)) || (frame_done && frame_err)) overlap_cnt++;
        if (busy) busy_cycles++;
    end

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    // Compare the n strobes recorded from index base against exp (first emitted bit = MSB of exp).
    task automatic check_strobes(input string name, input int base, input int n, input logic [15:0] exp);
        check({name, " strobe count"}, bit_q.size() - base, n);
        if (bit_q.size() - base == n) begin
            for (int i = 0; i < n; i++) begin
                check({name, " bit"}, int'(bit_q[base + i]), int'(exp[n - 1 - i]));
                if (i > 0 && (i % 8) != 0)
                    check({name, " strobe spacing"}, time_q[base + i] - time_q[base + i - 1], CPB);
            end
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          hold_low_bits;
        logic [15:0] exp_seq;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int q0, d0, e0, b0;

        // Expected sequences written in line order, LSB of data first.
        vecs[0] = '{8'h55, 1'b1, 0,  16'b10101010, 1, 0};
        vecs[1] = '{8'hA3, 1'b0, 20, 16'b11000101, 0, 1};
        vecs[2] = '{8'h0F, 1'b1, 0,  16'b11110000, 1, 0};

        // Reset state
        #90;
        check("reset outputs", int'({bit_out, bit_valid, frame_done, frame_err, busy}), 0);
        #10;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) send_bit(1'b1);
        check("idle strobes", bit_q.size(), 0);
        check("idle busy", int'(busy), 0);
        check("idle pulses", done_cnt + err_cnt, 0);

        // Table-driven frames
        for (int v = 0; v < 3; v++) begin
            q0 = bit_q.size();
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            repeat (2) @(negedge clk);
            check_strobes($sformatf("frame%0d", v), q0, 8, vecs[v].exp_seq);
            check($sformatf("frame%0d done", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("frame%0d err", v), err_cnt - e0, vecs[v].exp_err);
            if (vecs[v].hold_low_bits > 0) begin
                q0 = bit_q.size();
                repeat (vecs[v].hold_low_bits) send_bit(1'b0);
                check("break strobes", bit_q.size() - q0, 0);
                check("break busy", int'(busy), 1);
                check("break pulses", done_cnt + err_cnt - d0 - e0, 1);
            end
            repeat (2) send_bit(1'b1);
            check($sformatf("frame%0d idle after", v), int'(busy), 0);
        end

        // Start-bit glitch: two low cycles must be rejected
        q0 = bit_q.size();
        b0 = busy_cycles;
        d0 = done_cnt + err_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch strobes", bit_q.size() - q0, 0);
        check("glitch busy short", int'((busy_cycles - b0) >= 1 && (busy_cycles - b0) <= 6), 1);
        check("glitch pulses", done_cnt + err_cnt - d0, 0);
        check("glitch idle", int'(busy), 0);

        // Back-to-back frames
        q0 = bit_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b1);
        send_frame(8'hC3, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check_strobes("b2b", q0, 16, 16'b01011010_11000011);
        check("b2b done", done_cnt - d0, 2);
        check("b2b err", err_cnt - e0, 0);

        // Reset after the third strobe of a frame
        q0 = bit_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("pre-reset strobes", bit_q.size() - q0, 3);
        check("pre-reset busy", int'(busy), 1);
        #5;
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        check("async reset outputs", int'({bit_out, bit_valid, frame_done, frame_err, busy}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send_bit(1'b1);
        check("reset abort pulses", done_cnt + err_cnt - d0 - e0, 0);
        q0 = bit_q.size();
        d0 = done_cnt;
        send_frame(8'h96, 1'b1);
        repeat (2) @(negedge clk);
        check_strobes("post-reset", q0, 8, 16'b01101001);
        check("post-reset done", done_cnt - d0, 1);

        check("pulse overlap", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
